// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Buffer entries pair each fetched word with the byte PC it came from.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned WORD_IDX_W       = 30;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_index(input logic [31:0] addr);
        return {2'b00, addr[31:(32 - WORD_IDX_W)]};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of {pc, instr} entries sitting between instruction memory and decode.
// Flush empties the buffer and overrides any push or pop in the same cycle.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  push_data,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    fetch_entry_t  entries [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & (count != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (do_push) begin
            entries[wr_ptr] <= push_data;
        end
    end

    assign head = entries[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives word addresses to a 1-cycle
// synchronous instruction memory and hands {pc, instr} pairs to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        desvio_valido,
    input  logic [31:0] desvio_alvo,
    input  logic        id_ready,
    output logic [31:0] imem_endereco,
    input  logic [31:0] imem_instrucao,
    output logic        if_valid,
    output logic [31:0] if_instrucao,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_mais4,
    output logic        erro_alinhamento
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

    logic [31:0]   pc;
    logic [31:0]   fetch_addr;
    logic          pend;
    logic [31:0]   pend_pc;
    logic          pend_oob;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW-1:0] count;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    always_comb begin
        fetch_addr = pc;
        if (desvio_valido) fetch_addr = {desvio_alvo[31:2], 2'b00};
    end

    assign imem_endereco = word_index(fetch_addr);
    assign pop           = if_valid & id_ready & ~desvio_valido;
    assign push          = pend & ~desvio_valido;

    // The outstanding response already owns a slot; a same-cycle pop frees one.
    assign issue = desvio_valido |
                   ((32'(count) + 32'(pend)) < (32'(BUF_DEPTH) + 32'(pop)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc               <= RESET_PC;
            pend             <= 1'b0;
            pend_pc          <= '0;
            pend_oob         <= 1'b0;
            erro_alinhamento <= 1'b0;
        end else begin
            erro_alinhamento <= desvio_valido & (desvio_alvo[1:0] != 2'b00);
            pend             <= issue;
            if (issue) begin
                pc       <= fetch_addr + 32'd4;
                pend_pc  <= fetch_addr;
                pend_oob <= (imem_endereco >= MEM_WORDS);
            end
        end
    end

    always_comb begin
        push_entry.pc    = pend_pc;
        push_entry.instr = pend_oob ? NOP_INSTR : imem_instrucao;
    end

    fetch_buffer #(
        .DEPTH(BUF_DEPTH)
    ) u_buffer (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (desvio_valido),
        .push_data(push_entry),
        .head     (head),
        .count    (count)
    );

    assign if_valid     = (count != '0);
    assign if_pc        = if_valid ? head.pc : '0;
    assign if_instrucao = if_valid ? head.instr : '0;
    assign if_pc_mais4  = if_valid ? head.pc + 32'd4 : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// stream checked against an in-order expected-PC model of the fetch stream.
module tb_fetch_unit;

    localparam int unsigned MEM_WORDS = 32;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        desvio_valido = 1'b0;
    logic [31:0] desvio_alvo = '0;
    logic        id_ready = 1'b0;
    logic [31:0] imem_endereco;
    logic [31:0] imem_instrucao = '0;
    logic        if_valid;
    logic [31:0] if_instrucao;
    logic [31:0] if_pc;
    logic [31:0] if_pc_mais4;
    logic        erro_alinhamento;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] mem [MEM_WORDS];

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .BUF_DEPTH(2),
        .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .desvio_valido   (desvio_valido),
        .desvio_alvo     (desvio_alvo),
        .id_ready        (id_ready),
        .imem_endereco   (imem_endereco),
        .imem_instrucao  (imem_instrucao),
        .if_valid        (if_valid),
        .if_instrucao    (if_instrucao),
        .if_pc           (if_pc),
        .if_pc_mais4     (if_pc_mais4),
        .erro_alinhamento(erro_alinhamento)
    );

    always #5 clock = ~clock;

    // Synchronous-read instruction memory; out-of-range words return garbage.
    always @(posedge clock) begin
        if (imem_endereco < MEM_WORDS) imem_instrucao <= mem[imem_endereco[4:0]];
        else                           imem_instrucao <= $urandom;
    end

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        if ((pc >> 2) < MEM_WORDS) return mem[pc[6:2]];
        return NOP;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic restart();
        desvio_valido = 1'b0;
        id_ready = 1'b1;
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        id_ready = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) begin
            vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
            vectors++; if (if_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h expected 0", if_pc); end
            vectors++; if (if_instrucao !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h expected 0", if_instrucao); end
            vectors++; if (if_pc_mais4 !== 32'h0) begin miscompares++; $display("FAIL reset_pc4: got %h expected 0", if_pc_mais4); end
            vectors++; if (erro_alinhamento !== 1'b0) begin miscompares++; $display("FAIL reset_erro: got %b expected 0", erro_alinhamento); end
            vectors++; if (imem_endereco !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", imem_endereco); end
            step();
        end
    endtask

    task automatic test_release();
        logic [31:0] epc;
        restart();
        for (int k = 0; k < 8; k++) begin
            vectors++; if (imem_endereco !== 32'(k)) begin miscompares++; $display("FAIL seq_addr[%0d]: got %0d expected %0d", k, imem_endereco, k); end
            vectors++; if (if_valid !== (k >= 2)) begin miscompares++; $display("FAIL seq_valid[%0d]: got %b expected %b", k, if_valid, k >= 2); end
            if (k >= 2) begin
                epc = 32'(4 * (k - 2));
                vectors++; if (if_pc !== epc) begin miscompares++; $display("FAIL seq_pc[%0d]: got %h expected %h", k, if_pc, epc); end
                vectors++; if (if_instrucao !== mem[k-2]) begin miscompares++; $display("FAIL seq_instr[%0d]: got %h expected %h", k, if_instrucao, mem[k-2]); end
                vectors++; if (if_pc_mais4 !== epc + 32'd4) begin miscompares++; $display("FAIL seq_pc4[%0d]: got %h expected %h", k, if_pc_mais4, epc + 32'd4); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        restart();
        step();
        step();
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin miscompares++; $display("FAIL bp_hold[%0d]: got valid %b pc %h expected 1 00000000", i, if_valid, if_pc); end
            vectors++; if (if_instrucao !== mem[0]) begin miscompares++; $display("FAIL bp_instr[%0d]: got %h expected %h", i, if_instrucao, mem[0]); end
            vectors++; if (imem_endereco !== 32'd2) begin miscompares++; $display("FAIL bp_addr[%0d]: got %0d expected 2", i, imem_endereco); end
            step();
        end
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * i)) begin miscompares++; $display("FAIL bp_drain[%0d]: got valid %b pc %h expected 1 %h", i, if_valid, if_pc, 32'(4 * i)); end
            vectors++; if (if_instrucao !== mem[i]) begin miscompares++; $display("FAIL bp_drain_instr[%0d]: got %h expected %h", i, if_instrucao, mem[i]); end
            step();
        end
    endtask

    task automatic test_redirect_full();
        restart();
        step();
        step();
        desvio_valido = 1'b1;
        desvio_alvo = 32'h0000_0040;
        #1;
        vectors++; if (imem_endereco !== 32'd16) begin miscompares++; $display("FAIL redir_addr: got %0d expected 16", imem_endereco); end
        step();
        desvio_valido = 1'b0;
        vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL redir_squash: got valid %b pc %h expected 0", if_valid, if_pc); end
        step();
        for (int i = 0; i < 3; i++) begin
            vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h40 + 32'(4 * i)) begin miscompares++; $display("FAIL redir_pc[%0d]: got valid %b pc %h expected 1 %h", i, if_valid, if_pc, 32'h40 + 32'(4 * i)); end
            vectors++; if (if_instrucao !== mem[16+i]) begin miscompares++; $display("FAIL redir_instr[%0d]: got %h expected %h", i, if_instrucao, mem[16+i]); end
            step();
        end
    endtask

    task automatic test_misaligned();
        vectors++; if (erro_alinhamento !== 1'b0) begin miscompares++; $display("FAIL mis_before: got %b expected 0", erro_alinhamento); end
        desvio_valido = 1'b1;
        desvio_alvo = 32'h0000_0022;
        #1;
        vectors++; if (imem_endereco !== 32'd8) begin miscompares++; $display("FAIL mis_addr: got %0d expected 8", imem_endereco); end
        step();
        desvio_valido = 1'b0;
        vectors++; if (erro_alinhamento !== 1'b1) begin miscompares++; $display("FAIL mis_pulse: got %b expected 1", erro_alinhamento); end
        step();
        for (int i = 0; i < 2; i++) begin
            vectors++; if (erro_alinhamento !== 1'b0) begin miscompares++; $display("FAIL mis_after[%0d]: got %b expected 0", i, erro_alinhamento); end
            vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h20 + 32'(4 * i)) begin miscompares++; $display("FAIL mis_pc[%0d]: got valid %b pc %h expected 1 %h", i, if_valid, if_pc, 32'h20 + 32'(4 * i)); end
            vectors++; if (if_instrucao !== mem[8+i]) begin miscompares++; $display("FAIL mis_instr[%0d]: got %h expected %h", i, if_instrucao, mem[8+i]); end
            step();
        end
    endtask

    task automatic test_out_of_range();
        desvio_valido = 1'b1;
        desvio_alvo = 32'h0000_0080;
        #1;
        vectors++; if (imem_endereco !== 32'd32) begin miscompares++; $display("FAIL oob_addr: got %0d expected 32", imem_endereco); end
        step();
        desvio_valido = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h80 + 32'(4 * i)) begin miscompares++; $display("FAIL oob_pc[%0d]: got valid %b pc %h expected 1 %h", i, if_valid, if_pc, 32'h80 + 32'(4 * i)); end
            vectors++; if (if_instrucao !== NOP) begin miscompares++; $display("FAIL oob_instr[%0d]: got %h expected %h", i, if_instrucao, NOP); end
            vectors++; if (if_pc_mais4 !== 32'h84 + 32'(4 * i)) begin miscompares++; $display("FAIL oob_pc4[%0d]: got %h expected %h", i, if_pc_mais4, 32'h84 + 32'(4 * i)); end
            step();
        end
    endtask

    task automatic test_pc_wrap();
        desvio_valido = 1'b1;
        desvio_alvo = 32'hFFFF_FFF8;
        step();
        desvio_valido = 1'b0;
        step();
        vectors++; if (if_pc !== 32'hFFFF_FFF8 || if_instrucao !== NOP) begin miscompares++; $display("FAIL wrap_first: got pc %h instr %h expected fffffff8 %h", if_pc, if_instrucao, NOP); end
        step();
        vectors++; if (if_pc !== 32'hFFFF_FFFC || if_pc_mais4 !== 32'h0) begin miscompares++; $display("FAIL wrap_last: got pc %h pc4 %h expected fffffffc 00000000", if_pc, if_pc_mais4); end
        step();
        vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instrucao !== mem[0]) begin miscompares++; $display("FAIL wrap_zero: got valid %b pc %h instr %h expected 1 00000000 %h", if_valid, if_pc, if_instrucao, mem[0]); end
        step();
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        vectors++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instrucao !== 32'h0 || if_pc_mais4 !== 32'h0) begin miscompares++; $display("FAIL arst_clear: got valid %b pc %h instr %h pc4 %h expected all zero", if_valid, if_pc, if_instrucao, if_pc_mais4); end
        vectors++; if (imem_endereco !== 32'h0) begin miscompares++; $display("FAIL arst_addr: got %h expected 0", imem_endereco); end
        step();
        vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL arst_held: got %b expected 0", if_valid); end
        reset = 1'b1;
        step();
        vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL arst_lat: got %b expected 0", if_valid); end
        step();
        vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instrucao !== mem[0]) begin miscompares++; $display("FAIL arst_restart: got valid %b pc %h instr %h expected 1 00000000 %h", if_valid, if_pc, if_instrucao, mem[0]); end
        step();
    endtask

    // Decode must see consecutive PCs from the last start point, no bubbles
    // except the one cycle right after a redirect, and each word paired with its PC.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic        exp_err;
        logic        r1;
        logic        d;
        logic        rdy;
        logic [31:0] tgt;
        restart();
        step();
        step();
        exp_pc = 32'h0;
        exp_err = 1'b0;
        r1 = 1'b0;
        for (int n = 0; n < 600; n++) begin
            vectors++; if (if_valid !== ~r1) begin miscompares++; $display("FAIL rnd_valid[%0d]: got %b expected %b", n, if_valid, ~r1); end
            if (if_valid) begin
                vectors++; if (if_pc !== exp_pc) begin miscompares++; $display("FAIL rnd_pc[%0d]: got %h expected %h", n, if_pc, exp_pc); end
                vectors++; if (if_instrucao !== exp_instr(exp_pc)) begin miscompares++; $display("FAIL rnd_instr[%0d]: got %h expected %h", n, if_instrucao, exp_instr(exp_pc)); end
                vectors++; if (if_pc_mais4 !== exp_pc + 32'd4) begin miscompares++; $display("FAIL rnd_pc4[%0d]: got %h expected %h", n, if_pc_mais4, exp_pc + 32'd4); end
            end
            vectors++; if (erro_alinhamento !== exp_err) begin miscompares++; $display("FAIL rnd_erro[%0d]: got %b expected %b", n, erro_alinhamento, exp_err); end

            d   = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            tgt = ($urandom_range(0, 40) << 2) | $urandom_range(0, 3);
            desvio_valido = d;
            desvio_alvo = tgt;
            id_ready = rdy;
            if (d) begin
                #1;
                vectors++; if (imem_endereco !== (tgt >> 2)) begin miscompares++; $display("FAIL rnd_addr[%0d]: got %h expected %h", n, imem_endereco, tgt >> 2); end
            end

            if (d)                  exp_pc = tgt & ~32'h3;
            else if (rdy && if_valid) exp_pc = exp_pc + 32'd4;
            exp_err = d && (tgt[1:0] != 2'b00);
            r1 = d;
            step();
        end
        desvio_valido = 1'b0;
        id_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = $urandom;
        test_reset();
        test_release();
        test_backpressure();
        test_redirect_full();
        test_misaligned();
        test_out_of_range();
        test_pc_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory. Owns the program counter and issues word-indexed read addresses.
- Pairs each returned instruction with its PC and presents it to decode over a valid/ready interface.
- Absorbs the memory's 1-cycle synchronous read latency with a small output buffer.
- Handles branch redirects by squashing in-flight and buffered fetches.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- BUF_DEPTH, 2, output buffer entries (minimum 2; 2 gives 1 instr/cycle).
- MEM_WORDS, 32, number of valid instruction-memory words; word index >= MEM_WORDS is out of range.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- desvio_valido  in  1  redirect request from execute (taken branch/jump).
- desvio_alvo  in  32  redirect byte address.
- id_ready  in  1  decode accepts the current if_* word this cycle.
- imem_endereco  out  32  word index to instruction memory = {2'b00, addr[31:2]}.
- imem_instrucao  in  32  memory read data, valid the cycle after the address is presented.
- if_valid  out  1  if_* outputs hold a valid instruction.
- if_instrucao  out  32  fetched instruction.
- if_pc  out  32  byte PC of if_instrucao.
- if_pc_mais4  out  32  if_pc + 4 (mod 2^32).
- erro_alinhamento  out  1  registered 1-cycle pulse when desvio_alvo[1:0] != 0.

Behaviour:
- Reset (async, reset==0):
  - pc=RESET_PC, buffer empty, pend=0.
  - if_valid=0, if_instrucao=0, if_pc=0, if_pc_mais4=0, erro_alinhamento=0.
  - imem_endereco = RESET_PC>>2, but no request is counted while reset is held.
- State:
  - pc register.
  - pend flag, plus pend_pc and pend_oob for the single outstanding request.
  - BUF_DEPTH-entry FIFO of {pc, instr}.
- Address mux:
  - a = desvio_valido ? {desvio_alvo[31:2],2'b00} : pc.
  - imem_endereco = {2'b00, a[31:2]}.
- Issue rule:
  - credit = BUF_DEPTH - count - pend + pop, where pop = if_valid & id_ready & ~desvio_valido.
  - issue = desvio_valido | (credit > 0).
  - On issue: pend<=1, pend_pc<=a, pend_oob<=(a[31:2] >= MEM_WORDS), pc<=a+4.
  - With no issue: pc holds, pend<=0.
- Capture:
  - When pend==1 and no redirect, imem_instrucao is pushed at the clock edge as {pend_pc, pend_oob ? NOP : imem_instrucao}.
  - NOP = 32'h0000_0013.
- Latency:
  - Address issued in cycle N, data on imem_instrucao in N+1, if_valid in N+2.
  - Steady state with id_ready=1 is 1 instruction/cycle.
- Output: if_* reflect the FIFO head. Pop occurs when if_valid & id_ready.
- Backpressure:
  - id_ready=0 holds if_* stable.
  - Issue stops once count+pend reaches BUF_DEPTH, so no response is ever dropped and the FIFO never overflows.
- Redirect (desvio_valido=1 in cycle N):
  - Highest priority. FIFO is flushed, the outstanding response (arriving in N) is discarded, and any pop in N is ignored.
  - The target is issued in N; pc<=target+4; target instruction has if_valid in N+2.
- Misaligned target:
  - Bits [1:0] are forced to 00 and the redirect proceeds.
  - erro_alinhamento=1 in cycle N+1 only.
- Simultaneous push and pop: count is unchanged; pointers wrap modulo BUF_DEPTH.
- PC wrap: 32'hFFFF_FFFC + 4 = 0, with no flag.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); in-flight data is discarded.
- After reset deassert: the first issue is RESET_PC in the first cycle, so if_valid rises 2 cycles later.

Decomposition:
- Shared package/include fetch_pkg:
  - NOP_INSTR = 32'h0000_0013.
  - DEFAULT_RESET_PC.
  - Buffer-entry layout {pc[31:0], instr[31:0]}.
  - Word-index helper width.
- One sub-module: fetch_buffer, a parameterised BUF_DEPTH FIFO.
  - Signals: push, pop, flush, count, head data.
  - Async active-low reset, same clock.

Test Plan:
- Reset release with id_ready=1 and imem returning mem[i]:
  - imem_endereco sequence 0,1,2,3…
  - if_valid rises 2 cycles after release with if_pc=0, then if_pc=4,8,12 on consecutive cycles.
  - if_pc_mais4=if_pc+4.
- Backpressure, id_ready=0 for 5 cycles after the first valid:
  - if_* hold pc=0 and issue stops after count+pend=2.
  - On release, pcs 0,4,8 are delivered in order with no gap or duplicate.
- Redirect to 32'h0000_0040 while the FIFO is full and a response is pending:
  - Flushed and squashed entries never appear.
  - imem_endereco=16 that cycle; next if_valid carries if_pc=32'h40 two cycles later.
- Misaligned target desvio_alvo=32'h0000_0022:
  - Fetch proceeds at 32'h20.
  - erro_alinhamento pulses exactly 1 cycle.
- Out of range with MEM_WORDS=32, redirect to 32'h0000_0080:
  - if_instrucao=32'h0000_0013 and if_pc=32'h80, regardless of imem_instrucao.
- Async reset asserted mid-stream between clock edges:
  - if_valid drops to 0 immediately.
  - After deassert, fetch restarts at RESET_PC.
